// File: rtl/pi_cmd_queue.sv
// Pi-facing command queue: collects Pi register writes into bus requests,
// buffers them in a small FIFO and hands them one at a time to the bus engine.
module pi_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             SYSCLK,
    input  logic             nRESET,
    input  logic [2:0]       PI_A,
    input  logic             PI_WR,
    input  logic [15:0]      PI_DATA_IN,
    output logic             REQ_VALID,
    input  logic             REQ_READY,
    output logic [23:0]      REQ_ADDR,
    output logic [1:0]       REQ_SIZE,
    output logic             REQ_READ,
    output logic [2:0]       REQ_FC,
    output logic [31:0]      REQ_WDATA,
    input  logic             RSP_VALID,
    input  logic [31:0]      RSP_RDATA,
    output logic [31:0]      RD_DATA,
    output logic [LVL_W-1:0] Q_LEVEL,
    output logic             Q_FULL,
    output logic             BUSY,
    output logic             OVERFLOW
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [23:0] addr;
        logic [1:0]  size;
        logic        read;
        logic [2:0]  fc;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_RSP} state_t;

    logic             wr_meta_q, wr_sync_q, wr_prev_q;
    logic [15:0]      data_lo_q, data_lo_d;
    logic [15:0]      data_hi_q, data_hi_d;
    logic [15:0]      addr_lo_q, addr_lo_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    state_t           state_q, state_d;
    logic             req_valid_q, req_valid_d;
    entry_t           head_q, head_d;
    logic             rd_flag_q, rd_flag_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             overflow_q, overflow_d;

    entry_t           mem [DEPTH];

    logic             commit, push_req, push_ok, pop, full;
    entry_t           new_entry;
    logic             unused_pi_bits;

    assign unused_pi_bits = ^PI_DATA_IN[15:14];

    always_comb begin
        commit    = wr_prev_q & ~wr_sync_q;
        push_req  = commit && (PI_A == 3'd3);
        pop       = (state_q == OFFER) && REQ_READY;
        full      = (level_q == LVL_W'(DEPTH));
        // A pop on the same edge frees the slot the push needs.
        push_ok   = push_req && (!full || pop);
        new_entry = '{addr:  {PI_DATA_IN[7:0], addr_lo_q},
                      size:  PI_DATA_IN[9:8],
                      read:  PI_DATA_IN[10],
                      fc:    PI_DATA_IN[13:11],
                      wdata: {data_hi_q, data_lo_q}};

        data_lo_d   = data_lo_q;
        data_hi_d   = data_hi_q;
        addr_lo_d   = addr_lo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        state_d     = state_q;
        head_d      = head_q;
        rd_flag_d   = rd_flag_q;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;

        if (commit) begin
            case (PI_A)
                3'd0:    data_lo_d  = PI_DATA_IN;
                3'd1:    data_hi_d  = PI_DATA_IN;
                3'd2:    addr_lo_d  = PI_DATA_IN;
                3'd4:    overflow_d = 1'b0;
                default: ;
            endcase
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d = OFFER;
                    head_d  = mem[rd_ptr_q];
                end
            end
            OFFER: begin
                if (pop) begin
                    state_d   = WAIT_RSP;
                    rd_flag_d = head_q.read;
                end
            end
            WAIT_RSP: begin
                if (RSP_VALID) begin
                    if (rd_flag_q) begin
                        rd_data_d = RSP_RDATA;
                    end
                    if (level_d != '0) begin
                        state_d = OFFER;
                        // Empty queue plus a same-edge push: head comes straight from the write port.
                        head_d  = (level_q == '0) ? new_entry : mem[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_valid_d = (state_d == OFFER);
    end

    always_ff @(posedge SYSCLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_meta_q   <= 1'b1;
            wr_sync_q   <= 1'b1;
            wr_prev_q   <= 1'b1;
            data_lo_q   <= '0;
            data_hi_q   <= '0;
            addr_lo_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            head_q      <= '0;
            rd_flag_q   <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_meta_q   <= PI_WR;
            wr_sync_q   <= wr_meta_q;
            wr_prev_q   <= wr_sync_q;
            data_lo_q   <= data_lo_d;
            data_hi_q   <= data_hi_d;
            addr_lo_q   <= addr_lo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            head_q      <= head_d;
            rd_flag_q   <= rd_flag_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign REQ_VALID = req_valid_q;
    assign REQ_ADDR  = head_q.addr;
    assign REQ_SIZE  = head_q.size;
    assign REQ_READ  = head_q.read;
    assign REQ_FC    = head_q.fc;
    assign REQ_WDATA = head_q.wdata;
    assign RD_DATA   = rd_data_q;
    assign Q_LEVEL   = level_q;
    assign Q_FULL    = (level_q == LVL_W'(DEPTH));
    assign BUSY      = (state_q != IDLE) || (level_q != '0);
    assign OVERFLOW  = overflow_q;
endmodule

// File: tb/tb_pi_cmd_queue.sv
// Directed bench for pi_cmd_queue: expected requests are queued as the Pi
// writes are driven and checked as the queue offers them to the bus side.
module tb_pi_cmd_queue;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             SYSCLK = 1'b0;
    logic             nRESET;
    logic [2:0]       PI_A;
    logic             PI_WR;
    logic [15:0]      PI_DATA_IN;
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [23:0]      REQ_ADDR;
    logic [1:0]       REQ_SIZE;
    logic             REQ_READ;
    logic [2:0]       REQ_FC;
    logic [31:0]      REQ_WDATA;
    logic             RSP_VALID;
    logic [31:0]      RSP_RDATA;
    logic [31:0]      RD_DATA;
    logic [LVL_W-1:0] Q_LEVEL;
    logic             Q_FULL;
    logic             BUSY;
    logic             OVERFLOW;

    always #5 SYSCLK = ~SYSCLK;

    pi_cmd_queue #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .SYSCLK(SYSCLK), .nRESET(nRESET), .PI_A(PI_A), .PI_WR(PI_WR),
        .PI_DATA_IN(PI_DATA_IN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_READ(REQ_READ),
        .REQ_FC(REQ_FC), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA), .RD_DATA(RD_DATA), .Q_LEVEL(Q_LEVEL),
        .Q_FULL(Q_FULL), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
    );

    typedef struct {
        logic [23:0] addr;
        logic [1:0]  size;
        logic        rd;
        logic [2:0]  fc;
        logic [31:0] wdata;
    } ent_t;

    ent_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] stg_lo = '0;
    logic [15:0] stg_hi = '0;
    logic [31:0] rd_model = '0;
    logic        last_rd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pi_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge SYSCLK);
        PI_A = a; PI_DATA_IN = d; PI_WR = 1'b0;
        repeat (4) @(negedge SYSCLK);
        PI_WR = 1'b1;
        repeat (4) @(negedge SYSCLK);
        if (a == 3'd0) stg_lo = d;
        if (a == 3'd1) stg_hi = d;
        $display("pi_write a=%0d d=%h level=%0d", a, d, Q_LEVEL);
    endtask

    task automatic push_entry(input logic [23:0] addr, input logic [1:0] sz,
                              input logic rd, input logic [2:0] fc);
        ent_t e;
        pi_write(3'd2, addr[15:0]);
        pi_write(3'd3, {2'b00, fc, rd, sz, addr[23:16]});
        e.addr = addr; e.size = sz; e.rd = rd; e.fc = fc; e.wdata = {stg_hi, stg_lo};
        sb.push_back(e);
    endtask

    task automatic check_head(output logic rd);
        ent_t e;
        rd = 1'b0;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed=offer expected=no_offer");
        end else begin
            e = sb.pop_front();
            chk("head_addr", REQ_ADDR, e.addr);
            chk("head_size", REQ_SIZE, e.size);
            chk("head_read", REQ_READ, e.rd);
            chk("head_fc", REQ_FC, e.fc);
            chk("head_wdata", REQ_WDATA, e.wdata);
            rd = e.rd;
            $display("offer addr=%h size=%0d read=%0d fc=%0d wdata=%h", REQ_ADDR, REQ_SIZE, REQ_READ, REQ_FC, REQ_WDATA);
        end
    endtask

    task automatic accept_head();
        for (int i = 0; i < 20 && REQ_VALID !== 1'b1; i++) @(negedge SYSCLK);
        chk("req_valid_wait", REQ_VALID, 1);
        check_head(last_rd);
        REQ_READY = 1'b1;
        @(negedge SYSCLK);
        REQ_READY = 1'b0;
        chk("req_valid_after_pop", REQ_VALID, 0);
        chk("busy_in_flight", BUSY, 1);
    endtask

    task automatic complete(input logic [31:0] rdata);
        RSP_VALID = 1'b1; RSP_RDATA = rdata;
        @(negedge SYSCLK);
        RSP_VALID = 1'b0;
        if (last_rd) rd_model = rdata;
        chk("rd_data", RD_DATA, rd_model);
        $display("complete rdata=%h read=%0d RD_DATA=%h", rdata, last_rd, RD_DATA);
    endtask

    task automatic serve(input logic [31:0] rdata);
        accept_head();
        complete(rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        nRESET = 1'b0; PI_A = '0; PI_WR = 1'b1; PI_DATA_IN = '0;
        REQ_READY = 1'b0; RSP_VALID = 1'b0; RSP_RDATA = '0;
        repeat (3) @(negedge SYSCLK);
        chk("rst_req_valid", REQ_VALID, 0);
        chk("rst_level", Q_LEVEL, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_overflow", OVERFLOW, 0);
        chk("rst_rd_data", RD_DATA, 0);
        chk("rst_req_addr", REQ_ADDR, 0);
        nRESET = 1'b1;
        @(negedge SYSCLK);

        // Single read request with strobe-to-offer latency
        pi_write(3'd0, 16'h1234);
        pi_write(3'd1, 16'hABCD);
        pi_write(3'd2, 16'h0100);
        @(negedge SYSCLK);
        PI_A = 3'd3; PI_DATA_IN = 16'h0D02; PI_WR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge SYSCLK);
            chk("lat_req_valid_low", REQ_VALID, 0);
        end
        chk("lat_level_after_push", Q_LEVEL, 1);
        @(negedge SYSCLK);
        chk("lat_req_valid_high", REQ_VALID, 1);
        PI_WR = 1'b1;
        repeat (4) @(negedge SYSCLK);
        e.addr = 24'h020100; e.size = 2'd1; e.rd = 1'b1; e.fc = 3'd1; e.wdata = 32'hABCD1234;
        sb.push_back(e);
        serve(32'hCAFEF00D);
        chk("t1_busy", BUSY, 0);
        chk("t1_rd_data", RD_DATA, 32'hCAFEF00D);

        // Fill, overflow, clear, drain in order
        for (int i = 0; i < 4; i++) push_entry(24'(i), 2'd2, 1'b0, 3'd5);
        chk("full_level", Q_LEVEL, 4);
        chk("full_flag", Q_FULL, 1);
        chk("full_no_overflow", OVERFLOW, 0);
        pi_write(3'd3, 16'h2A00);
        chk("drop_overflow", OVERFLOW, 1);
        chk("drop_level", Q_LEVEL, 4);
        pi_write(3'd4, 16'h0000);
        chk("status_clears", OVERFLOW, 0);
        for (int i = 0; i < 4; i++) serve(32'h0);
        chk("drain_level", Q_LEVEL, 0);
        chk("drain_full", Q_FULL, 0);
        chk("drain_busy", BUSY, 0);

        // Push on the same edge as a pop while full
        pi_write(3'd0, 16'h5555);
        for (int i = 0; i < 4; i++) push_entry(24'h10 + 24'(i), 2'd0, 1'b0, 3'd2);
        pi_write(3'd2, 16'h0020);
        @(negedge SYSCLK);
        PI_A = 3'd3; PI_DATA_IN = {2'b00, 3'd2, 1'b0, 2'd0, 8'h00}; PI_WR = 1'b0;
        @(negedge SYSCLK);
        @(negedge SYSCLK);
        chk("sim_req_valid", REQ_VALID, 1);
        check_head(last_rd);
        REQ_READY = 1'b1;
        @(negedge SYSCLK);
        REQ_READY = 1'b0;
        chk("sim_level", Q_LEVEL, 4);
        chk("sim_overflow", OVERFLOW, 0);
        chk("sim_full", Q_FULL, 1);
        e.addr = 24'h000020; e.size = 2'd0; e.rd = 1'b0; e.fc = 3'd2; e.wdata = {stg_hi, stg_lo};
        sb.push_back(e);
        @(negedge SYSCLK);
        PI_WR = 1'b1;
        repeat (4) @(negedge SYSCLK);
        complete(32'h0);
        for (int i = 0; i < 4; i++) serve(32'h0);
        chk("sim_drain_level", Q_LEVEL, 0);

        // Nine rounds to wrap the pointers
        for (int i = 0; i < 9; i++) begin
            pi_write(3'd0, 16'h0100 + 16'(i));
            push_entry(24'h300000 + 24'(i), 2'(i % 4), 1'b1, 3'(i % 8));
            serve(32'hA0000000 + 32'(i));
        end
        chk("wrap_level", Q_LEVEL, 0);

        // Write completion keeps RD_DATA; spurious RSP_VALID ignored
        push_entry(24'h400000, 2'd2, 1'b1, 3'd1);
        serve(32'h11112222);
        push_entry(24'h400004, 2'd2, 1'b0, 3'd1);
        serve(32'hDEADBEEF);
        chk("wr_keeps_rd_data", RD_DATA, 32'h11112222);
        RSP_VALID = 1'b1; RSP_RDATA = 32'h99999999;
        @(negedge SYSCLK);
        RSP_VALID = 1'b0;
        @(negedge SYSCLK);
        chk("spur_rd_data", RD_DATA, 32'h11112222);
        chk("spur_req_valid", REQ_VALID, 0);
        chk("spur_busy", BUSY, 0);

        // Reset in WAIT_RSP with two entries queued
        for (int i = 0; i < 3; i++) push_entry(24'h500000 + 24'(i), 2'd1, 1'b0, 3'd3);
        accept_head();
        chk("pre_rst_level", Q_LEVEL, 2);
        #2 nRESET = 1'b0;
        #1;
        chk("mid_rst_req_valid", REQ_VALID, 0);
        chk("mid_rst_level", Q_LEVEL, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_rd_data", RD_DATA, 0);
        chk("mid_rst_addr", REQ_ADDR, 0);
        chk("mid_rst_wdata", REQ_WDATA, 0);
        sb.delete();
        stg_lo = '0; stg_hi = '0; rd_model = '0;
        @(negedge SYSCLK);
        nRESET = 1'b1;
        @(negedge SYSCLK);
        RSP_VALID = 1'b1; RSP_RDATA = 32'h77777777;
        @(negedge SYSCLK);
        RSP_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge SYSCLK);
            chk("post_rst_req_valid", REQ_VALID, 0);
            chk("post_rst_rd_data", RD_DATA, 0);
        end
        push_entry(24'h000055, 2'd0, 1'b1, 3'd0);
        serve(32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pi_cmd_queue.md
# pi_cmd_queue

Upstream stage of the Amiga bus engine: receives Pi register writes over the GPIO port, assembles complete bus requests, and buffers them in a small FIFO. It presents one request at a time to the bus state machine over a valid/ready handshake and waits for its completion. It also captures returned read data and exposes queue status back to the Pi. It allows the Pi to post several writes back-to-back without polling `req_active` between them.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `LVL_W`, clog2(DEPTH)+1: width of `Q_LEVEL`.

Ports:
- `SYSCLK` in 1: PLL system clock; only clock.
- `nRESET` in 1: asynchronous, active-low reset.
- `PI_A` in 3: Pi register address. 0=DATA_LO, 1=DATA_HI, 2=ADDR_LO, 3=ADDR_HI, 4=STATUS; others ignored.
- `PI_WR` in 1: asynchronous Pi write strobe, active low; commit on falling edge.
- `PI_DATA_IN` in 16: Pi write data.
- `REQ_VALID` out 1: head entry offered to bus engine.
- `REQ_READY` in 1: bus engine accepts head.
- `REQ_ADDR` out 24, `REQ_SIZE` out 2, `REQ_READ` out 1, `REQ_FC` out 3, `REQ_WDATA` out 32: head entry fields.
- `RSP_VALID` in 1: one-cycle completion pulse from bus engine.
- `RSP_RDATA` in 32: read data, valid with `RSP_VALID`.
- `RD_DATA` out 32: data of last completed read.
- `Q_LEVEL` out LVL_W: entries queued, excluding the one in flight.
- `Q_FULL` out 1, `BUSY` out 1, `OVERFLOW` out 1: status.

## Operation
- **Strobe sync:** `PI_WR` passes through a 2-flop synchronizer (reset value 1). Commit when the synced pair is old=1/new=0. Latch `PI_A` and `PI_DATA_IN` on the same edge. The Pi must hold each strobe phase for at least 3 `SYSCLK` cycles.
- **Staging registers:**
  - DATA_LO writes wdata[15:0]; DATA_HI writes wdata[31:16]; ADDR_LO writes addr[15:0].
  - Staging registers keep their values after a push, so the Pi can reuse them.
- **Push:** an ADDR_HI commit pushes one entry built as follows:
  - addr = {PI_DATA_IN[7:0], addr_lo}
  - size = [9:8]
  - read = [10]
  - fc = [13:11]
  - wdata = staged data
- **STATUS commit:** clears `OVERFLOW`. No other effect.
- **Full:**
  - A push while full is dropped and sets `OVERFLOW` (sticky).
  - Exception: if a pop occurs in the same cycle, the push is accepted and the level is unchanged.
- **FIFO:** read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Level is an explicit counter: +1 on push, -1 on pop, unchanged on both or neither.
- **Handshake FSM:**
  - IDLE: queue empty, nothing outstanding.
  - OFFER: `REQ_VALID`=1.
  - WAIT_RSP: one request in flight.
  - IDLE→OFFER when level>0.
  - OFFER→WAIT_RSP when `REQ_VALID`&`REQ_READY` at a posedge; head is popped and its read flag latched.
  - WAIT_RSP→OFFER on `RSP_VALID` if level>0 after this cycle's push/pop, else →IDLE.
- **Completion:** on `RSP_VALID` in WAIT_RSP with the latched read flag set, `RD_DATA`←`RSP_RDATA`. Write completions leave `RD_DATA` unchanged.
- **Ignored events:** `RSP_VALID` outside WAIT_RSP; `REQ_READY` outside OFFER.
- **Status outputs:** `BUSY` = (state≠IDLE) | (level≠0). `Q_FULL` = (level==DEPTH).

## Timing
- **Reset values** (asynchronous, all outputs): 0, except the synchronizer flops, which reset to 1. FSM resets to IDLE; pointers, level, staging registers, `RD_DATA` and `OVERFLOW` reset to 0.
- **Reset mid-operation:** discards queue, staged data and the in-flight request. A `RSP_VALID` after reset is ignored.
- **PI_WR latency:** if `PI_WR` falls before edge k, the commit happens at edge k+2.
- **Push to `REQ_VALID` (empty queue, IDLE):** the entry is written at edge k+2, FSM enters OFFER at k+3, and `REQ_VALID` is high after k+3.
- **Head fields:** registered outputs of the head entry, stable while `REQ_VALID`=1.
- **Pop to next offer:** next `REQ_VALID` no earlier than the cycle after the edge that samples `RSP_VALID`. Only one request is outstanding at a time.
- **Level update:** `Q_LEVEL` and `Q_FULL` update on the edge of the push or pop.
- **OVERFLOW:** set on the edge of the dropped push.

## Test plan
- Stage DATA_LO=0x1234, DATA_HI=0xABCD, ADDR_LO=0x0100, then ADDR_HI=0x0D02 (read=1, size=1, fc=1, addr hi=0x02) → `REQ_VALID` 3 cycles after the ADDR_HI strobe with `REQ_ADDR`=0x020100, `REQ_SIZE`=1, `REQ_READ`=1, `REQ_FC`=1. Then `RSP_VALID` with 0xCAFEF00D → `RD_DATA`=0xCAFEF00D, `BUSY`=0.
- `REQ_READY`=0, push 4 writes with addr 0..3 (DEPTH=4) → `Q_FULL`=1. A 5th push → dropped, `OVERFLOW`=1. STATUS write → `OVERFLOW`=0. Release `REQ_READY` → entries emerge in addresses order 0,1,2,3.
- Queue full and in OFFER, push on the same edge as the `REQ_READY` pop → push accepted, `Q_LEVEL` stays 4, `OVERFLOW`=0.
- 9 push/complete rounds with DEPTH=4 → pointers wrap twice, order and data intact, `Q_LEVEL` returns to 0.
- Write completion after read 0x11112222 → `RD_DATA` remains 0x11112222. Spurious `RSP_VALID` in IDLE → no change.
- Assert `nRESET` in WAIT_RSP with 2 entries queued → all outputs 0 immediately. A later `RSP_VALID` is ignored and `REQ_VALID` stays 0.
